// File: rtl/wb_bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the Wishbone slave and a user requester.
// Optional grant counters are built when ARB_STATS_EN is defined.
module wb_bram_arbiter #(
   parameter int          ADDR_W = 12,
   parameter int          DELAYS = 10,
   parameter logic [11:0] BASE   = 12'h380
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_dat_i,
   input  logic [31:0]       wbs_adr_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              usr_req_i,
   input  logic              usr_we_i,
   input  logic [3:0]        usr_sel_i,
   input  logic [ADDR_W-1:0] usr_adr_i,
   input  logic [31:0]       usr_dat_i,
   output logic              usr_gnt_o,
   output logic              usr_vld_o,
   output logic [31:0]       usr_dat_o,
   output logic              bram_en_o,
   output logic [3:0]        bram_we_o,
   output logic [31:0]       bram_adr_o,
   output logic [31:0]       bram_di_o,
`ifdef ARB_STATS_EN
   output logic [15:0]       stat_wb_o,
   output logic [15:0]       stat_usr_o,
`endif
   input  logic [31:0]       bram_do_i
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WB_BUSY = 2'd1;
   localparam logic [1:0] S_WB_ACK  = 2'd2;
   localparam logic [1:0] S_USR     = 2'd3;
   localparam logic [7:0] CNT_LAST  = 8'(DELAYS - 1);

   logic [1:0]        state;
   logic [7:0]        cnt;
   logic              last_usr;
   logic [ADDR_W-1:0] wb_adr_q;
   logic [3:0]        wb_sel_q;
   logic              wb_we_q;
   logic [31:0]       wb_dat_q;
   logic              usr_vld_q;
   logic [ADDR_W-1:0] bram_word;

   wire wb_valid = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:20] == BASE);
   wire wb_wins  = wb_valid & (~usr_req_i | last_usr);
   wire usr_wins = usr_req_i & (~wb_valid | ~last_usr);
   wire unused_adr_bits = ^{wbs_adr_i[19:ADDR_W+2], wbs_adr_i[1:0]};

   // Ties go to whoever was not granted last; the WB request is latched at grant time
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         last_usr  <= 1'b1;
         wb_adr_q  <= '0;
         wb_sel_q  <= 4'd0;
         wb_we_q   <= 1'b0;
         wb_dat_q  <= 32'd0;
         usr_vld_q <= 1'b0;
      end else begin
         usr_vld_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (wb_wins) begin
                  state    <= S_WB_BUSY;
                  cnt      <= 8'd0;
                  last_usr <= 1'b0;
                  wb_adr_q <= wbs_adr_i[ADDR_W+1:2];
                  wb_sel_q <= wbs_sel_i;
                  wb_we_q  <= wbs_we_i;
                  wb_dat_q <= wbs_dat_i;
               end else if (usr_wins) begin
                  state    <= S_USR;
                  last_usr <= 1'b1;
               end
            end
            S_WB_BUSY: begin
               if (!wbs_cyc_i)
                  state <= S_IDLE;
               else if (cnt == CNT_LAST)
                  state <= S_WB_ACK;
               else
                  cnt <= cnt + 8'd1;
            end
            S_WB_ACK: state <= S_IDLE;
            default: begin
               state     <= S_IDLE;
               usr_vld_q <= ~usr_we_i;
            end
         endcase
      end
   end

   // Only the write cycle of a WB access carries byte enables; later busy cycles re-read
   always_comb begin
      bram_en_o = 1'b0;
      bram_we_o = 4'd0;
      bram_word = '0;
      bram_di_o = 32'd0;
      wbs_ack_o = 1'b0;
      wbs_dat_o = 32'd0;
      usr_gnt_o = 1'b0;
      case (state)
         S_WB_BUSY: begin
            bram_en_o = 1'b1;
            bram_word = wb_adr_q;
            bram_di_o = wb_dat_q;
            if (cnt == 8'd0)
               bram_we_o = wb_sel_q & {4{wb_we_q}};
         end
         S_WB_ACK: begin
            wbs_ack_o = 1'b1;
            if (!wb_we_q)
               wbs_dat_o = bram_do_i;
         end
         S_USR: begin
            bram_en_o = 1'b1;
            bram_we_o = usr_sel_i & {4{usr_we_i}};
            bram_word = usr_adr_i;
            bram_di_o = usr_dat_i;
            usr_gnt_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign bram_adr_o = {{(30-ADDR_W){1'b0}}, bram_word, 2'b00};
   assign usr_vld_o  = usr_vld_q;
   assign usr_dat_o  = usr_vld_q ? bram_do_i : 32'd0;

`ifdef ARB_STATS_EN
   // Saturating counts of completed WB acks and user grants
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         stat_wb_o  <= 16'd0;
         stat_usr_o <= 16'd0;
      end else begin
         if (state == S_WB_ACK && stat_wb_o != 16'hFFFF)
            stat_wb_o <= stat_wb_o + 16'd1;
         if (state == S_USR && stat_usr_o != 16'hFFFF)
            stat_usr_o <= stat_usr_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Self-checking bench for wb_bram_arbiter: directed scenarios plus random WB/user traffic
// checked against a transaction-level model of grant order, latency and memory contents.
module tb_wb_bram_arbiter;

   localparam int D = 10;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b0;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i, wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        usr_req_i, usr_we_i;
   logic [3:0]  usr_sel_i;
   logic [11:0] usr_adr_i;
   logic [31:0] usr_dat_i;
   logic        usr_gnt_o, usr_vld_o;
   logic [31:0] usr_dat_o;
   logic        bram_en_o;
   logic [3:0]  bram_we_o;
   logic [31:0] bram_adr_o, bram_di_o;
   logic [31:0] bram_do_i;
`ifdef ARB_STATS_EN
   logic [15:0] stat_wb_o, stat_usr_o;
`endif

   wb_bram_arbiter #(.ADDR_W(12), .DELAYS(D), .BASE(12'h380)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .usr_req_i(usr_req_i), .usr_we_i(usr_we_i), .usr_sel_i(usr_sel_i),
      .usr_adr_i(usr_adr_i), .usr_dat_i(usr_dat_i),
      .usr_gnt_o(usr_gnt_o), .usr_vld_o(usr_vld_o), .usr_dat_o(usr_dat_o),
      .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_adr_o(bram_adr_o),
      .bram_di_o(bram_di_o),
`ifdef ARB_STATS_EN
      .stat_wb_o(stat_wb_o), .stat_usr_o(stat_usr_o),
`endif
      .bram_do_i(bram_do_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Single-port BRAM with one-cycle registered read
   bit [31:0] mem [4096];
   always @(posedge wb_clk_i) begin
      if (bram_en_o) begin
         bram_do_i <= mem[bram_adr_o[13:2]];
         for (int b = 0; b < 4; b++)
            if (bram_we_o[b]) mem[bram_adr_o[13:2]][8*b +: 8] <= bram_di_o[8*b +: 8];
      end
   end

   int total = 0;
   int bad = 0;

   // Reference model state
   logic [31:0] refMem [int];
   bit  lastUsr = 1'b1;
   int  cntWb = 0;
   int  cntUsr = 0;

   // Observations from one stimulus window
   int ackCnt, ackCyc, gntCnt, gntCyc, vldCnt, vldCyc, weCnt, datLeak;
   logic [31:0] ackDat, vldDat;
   logic [3:0]  weOr;

   function automatic logic [31:0] refRead(input int w);
      return refMem.exists(w) ? refMem[w] : 32'h0;
   endfunction

   task automatic refWrite(input int w, input logic [3:0] sel, input logic [31:0] dat);
      logic [31:0] v;
      v = refRead(w);
      for (int b = 0; b < 4; b++)
         if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
      refMem[w] = v;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic clearInputs();
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'd0;
      wbs_dat_i = 32'd0; wbs_adr_i = 32'd0;
      usr_req_i = 1'b0; usr_we_i = 1'b0; usr_sel_i = 4'd0; usr_adr_i = 12'd0; usr_dat_i = 32'd0;
   endtask

   task automatic doReset();
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      lastUsr = 1'b1; cntWb = 0; cntUsr = 0;
      @(negedge wb_clk_i);
   endtask

   // Raises the requests together, then watches a fixed window of cycles
   task automatic applyStimulus(input bit doWb, input bit wbWe, input logic [31:0] wbAdr,
                                input logic [3:0] wbSel, input logic [31:0] wbDat,
                                input bit doUsr, input bit usrWe, input logic [11:0] usrAdr,
                                input logic [3:0] usrSel, input logic [31:0] usrDat, input int dropAt);
      ackCnt = 0; ackCyc = 0; gntCnt = 0; gntCyc = 0; vldCnt = 0; vldCyc = 0;
      weCnt = 0; datLeak = 0; ackDat = 32'd0; vldDat = 32'd0; weOr = 4'd0;
      wbs_stb_i = doWb; wbs_cyc_i = doWb; wbs_we_i = wbWe; wbs_sel_i = wbSel;
      wbs_adr_i = wbAdr; wbs_dat_i = wbDat;
      usr_req_i = doUsr; usr_we_i = usrWe; usr_sel_i = usrSel; usr_adr_i = usrAdr; usr_dat_i = usrDat;
      for (int c = 1; c <= 2*D + 8; c++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            ackCnt++;
            if (ackCnt == 1) begin ackCyc = c; ackDat = wbs_dat_o; end
            wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
         end else if (wbs_dat_o !== 32'd0) datLeak++;
         if (usr_gnt_o) begin
            gntCnt++;
            if (gntCnt == 1) gntCyc = c;
            usr_req_i = 1'b0;
         end
         if (usr_vld_o) begin
            vldCnt++;
            if (vldCnt == 1) begin vldCyc = c; vldDat = usr_dat_o; end
         end
         if (bram_we_o != 4'd0) begin weCnt++; weOr = weOr | bram_we_o; end
         if (dropAt == c) begin wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; end
      end
      clearInputs();
   endtask

   task automatic runCase(input string tag, input bit doWb, input bit wbWe, input logic [31:0] wbAdr,
                          input logic [3:0] wbSel, input logic [31:0] wbDat,
                          input bit doUsr, input bit usrWe, input logic [11:0] usrAdr,
                          input logic [3:0] usrSel, input logic [31:0] usrDat, input int dropAt);
      bit wbOk, wbFirst, wbTurn;
      int wbStart, usrStart, expAck, expWeCnt;
      logic [31:0] expAckDat, expVldDat;
      logic [3:0] expWeOr;
      wbOk    = doWb && (wbAdr[31:20] == 12'h380);
      wbFirst = wbOk && (!doUsr || lastUsr);
      wbStart = 1; usrStart = 1;
      if (wbOk && doUsr) begin
         if (wbFirst) usrStart = D + 3;
         else         wbStart  = 3;
      end
      expAck = (wbOk && dropAt == 0) ? 1 : 0;
      expAckDat = 32'd0; expVldDat = 32'd0;
      for (int step = 0; step < 2; step++) begin
         wbTurn = ((step == 0) == wbFirst);
         if (wbTurn && wbOk) begin
            if (wbWe) refWrite(int'(wbAdr[13:2]), wbSel, wbDat);
            else      expAckDat = refRead(int'(wbAdr[13:2]));
            lastUsr = 1'b0;
            cntWb += expAck;
         end else if (!wbTurn && doUsr) begin
            if (usrWe) refWrite(int'(usrAdr), usrSel, usrDat);
            else       expVldDat = refRead(int'(usrAdr));
            lastUsr = 1'b1;
            cntUsr++;
         end
      end
      expWeCnt = ((wbOk && wbWe && wbSel != 0) ? 1 : 0) + ((doUsr && usrWe && usrSel != 0) ? 1 : 0);
      expWeOr  = ((wbOk && wbWe) ? wbSel : 4'd0) | ((doUsr && usrWe) ? usrSel : 4'd0);

      applyStimulus(doWb, wbWe, wbAdr, wbSel, wbDat, doUsr, usrWe, usrAdr, usrSel, usrDat, dropAt);

      checkOutput({tag, " ack_count"}, ackCnt, expAck);
      if (expAck == 1) begin
         checkOutput({tag, " ack_cycle"}, ackCyc, wbStart + D);
         checkOutput({tag, " ack_data"}, ackDat, expAckDat);
      end
      checkOutput({tag, " gnt_count"}, gntCnt, doUsr ? 1 : 0);
      if (doUsr) checkOutput({tag, " gnt_cycle"}, gntCyc, usrStart);
      checkOutput({tag, " vld_count"}, vldCnt, (doUsr && !usrWe) ? 1 : 0);
      if (doUsr && !usrWe) begin
         checkOutput({tag, " vld_cycle"}, vldCyc, usrStart + 1);
         checkOutput({tag, " vld_data"}, vldDat, expVldDat);
      end
      checkOutput({tag, " we_count"}, weCnt, expWeCnt);
      checkOutput({tag, " we_mask"}, 32'(weOr), 32'(expWeOr));
      checkOutput({tag, " dat_idle_zero"}, datLeak, 0);
`ifdef ARB_STATS_EN
      checkOutput({tag, " stat_wb"}, 32'(stat_wb_o), cntWb);
      checkOutput({tag, " stat_usr"}, 32'(stat_usr_o), cntUsr);
`endif
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " ack"}, 32'(wbs_ack_o), 0);
      checkOutput({tag, " wb_dat"}, wbs_dat_o, 0);
      checkOutput({tag, " gnt"}, 32'(usr_gnt_o), 0);
      checkOutput({tag, " vld"}, 32'(usr_vld_o), 0);
      checkOutput({tag, " usr_dat"}, usr_dat_o, 0);
      checkOutput({tag, " bram_en"}, 32'(bram_en_o), 0);
      checkOutput({tag, " bram_we"}, 32'(bram_we_o), 0);
      checkOutput({tag, " bram_adr"}, bram_adr_o, 0);
      checkOutput({tag, " bram_di"}, bram_di_o, 0);
`ifdef ARB_STATS_EN
      checkOutput({tag, " stat_wb"}, 32'(stat_wb_o), 0);
      checkOutput({tag, " stat_usr"}, 32'(stat_usr_o), 0);
`endif
   endtask

   initial begin
      bit rw, ru;
      int wa, ua;
      clearInputs();
      #2 wb_rst_i = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      checkAllZero("reset");
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);

      $display("[TB] basic WB write/read and byte selects");
      runCase("wr_full", 1, 1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 0, 0, 12'd0, 4'd0, 32'd0, 0);
      runCase("rd_full", 1, 0, 32'h3800_0010, 4'hF, 32'd0,         0, 0, 12'd0, 4'd0, 32'd0, 0);
      runCase("wr_low16", 1, 1, 32'h3800_0010, 4'b0011, 32'h0000_1234, 0, 0, 12'd0, 4'd0, 32'd0, 0);
      runCase("rd_merged", 1, 0, 32'h3800_0010, 4'hF, 32'd0,       0, 0, 12'd0, 4'd0, 32'd0, 0);

      $display("[TB] simultaneous requests after reset");
      doReset();
      runCase("tie_wb_first", 1, 1, 32'h3800_0020, 4'hF, 32'h1111_2222, 1, 0, 12'd8, 4'hF, 32'd0, 0);
      runCase("tie_usr_first", 1, 0, 32'h3800_0020, 4'hF, 32'd0, 1, 1, 12'd8, 4'b1100, 32'hABCD_0000, 0);

      $display("[TB] user read of WB-written word");
      runCase("wb_a5", 1, 1, 32'h3800_0010, 4'hF, 32'hA5A5_A5A5, 0, 0, 12'd0, 4'd0, 32'd0, 0);
      runCase("usr_rd4", 0, 0, 32'd0, 4'd0, 32'd0, 1, 0, 12'd4, 4'hF, 32'd0, 0);

      $display("[TB] bad base and cycle abort");
      runCase("bad_base", 1, 1, 32'h3000_0000, 4'hF, 32'hFFFF_FFFF, 0, 0, 12'd0, 4'd0, 32'd0, 0);
      runCase("rd_after_bad", 0, 0, 32'd0, 4'd0, 32'd0, 1, 0, 12'd0, 4'hF, 32'd0, 0);
      runCase("abort_wr", 1, 1, 32'h3800_0030, 4'hF, 32'h5A5A_0F0F, 0, 0, 12'd0, 4'd0, 32'd0, 3);
      runCase("rd_after_abort", 1, 0, 32'h3800_0030, 4'hF, 32'd0, 0, 0, 12'd0, 4'd0, 32'd0, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 24; i++) begin
         rw = 1'($urandom_range(0, 1));
         ru = 1'($urandom_range(0, 1));
         if (!rw && !ru) rw = 1'b1;
         wa = $urandom_range(0, 7);
         ua = $urandom_range(0, 7);
         runCase($sformatf("rnd%0d", i),
                 rw, 1'($urandom_range(0, 1)), 32'h3800_0000 | 32'(wa << 2), 4'($urandom), $urandom,
                 ru, 1'($urandom_range(0, 1)), 12'(ua), 4'($urandom), $urandom, 0);
      end

      $display("[TB] reset during WB busy");
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3800_0010;
      repeat (4) @(negedge wb_clk_i);
      checkOutput("busy_en_before_reset", 32'(bram_en_o), 1);
      wb_rst_i = 1'b1;
      #1;
      checkAllZero("mid_reset");
      clearInputs();
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      lastUsr = 1'b1; cntWb = 0; cntUsr = 0;
      @(negedge wb_clk_i);
      runCase("post_reset_tie", 1, 0, 32'h3800_0010, 4'hF, 32'd0, 1, 0, 12'd4, 4'hF, 32'd0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
